// File: rtl/spi_bitrev_slave.sv
// SPI slave loopback target: receives a DATA_W-bit word, then returns it
// bit-reversed or echoed, repeating RX/TX pairs while ss stays low.
module spi_bitrev_slave #(
    parameter int unsigned DATA_W  = 8,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0,
    parameter bit          REVERSE = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned    CW   = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RX   = 2'b01,
        S_TX   = 2'b10
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_tx;
    logic              r_miso;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;

    logic [1:0]        r_sck_s;
    logic              r_sck_d;
    logic [1:0]        r_ss_s;
    logic [1:0]        r_mosi_s;

    state_t            w_state;
    logic [CW-1:0]     w_cnt;
    logic [DATA_W-1:0] w_sr;
    logic [DATA_W-1:0] w_tx;
    logic              w_miso;
    logic [DATA_W-1:0] w_rx_data;
    logic              w_rx_valid;
    logic              w_frame_err;

    logic              w_rise;
    logic              w_fall;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shift;
    logic [DATA_W-1:0] w_sr_in;

    function automatic logic [DATA_W-1:0] f_rev(input logic [DATA_W-1:0] d);
        for (int i = 0; i < int'(DATA_W); i++) begin
            f_rev[i] = d[DATA_W-1-i];
        end
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sck_s  <= {CPOL, CPOL};
            r_sck_d  <= CPOL;
            r_ss_s   <= 2'b11;
            r_mosi_s <= 2'b00;
        end else begin
            r_sck_s  <= {r_sck_s[0], sck};
            r_sck_d  <= r_sck_s[1];
            r_ss_s   <= {r_ss_s[0], ss};
            r_mosi_s <= {r_mosi_s[0], mosi};
        end
    end

    assign w_rise   = r_sck_s[1] & ~r_sck_d;
    assign w_fall   = ~r_sck_s[1] & r_sck_d;
    assign w_lead   = CPOL ? w_fall : w_rise;
    assign w_trail  = CPOL ? w_rise : w_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead : w_trail;
    assign w_sr_in  = {r_sr[DATA_W-2:0], r_mosi_s[1]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_sr        <= w_sr;
            r_tx        <= w_tx;
            r_miso      <= w_miso;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_sr        = r_sr;
        w_tx        = r_tx;
        w_miso      = r_miso;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_frame_err = 1'b0;
        // A deselect overrides any sck edge seen in the same cycle.
        if (r_ss_s[1]) begin
            w_state     = S_IDLE;
            w_cnt       = '0;
            w_miso      = 1'b1;
            w_frame_err = (r_cnt != '0) || (r_state == S_TX);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state = S_RX;
                end
                S_RX: begin
                    if (w_shift) w_miso = 1'b1;
                    if (w_sample) begin
                        w_sr = w_sr_in;
                        if (r_cnt == LAST) begin
                            w_cnt      = '0;
                            w_rx_data  = w_sr_in;
                            w_rx_valid = 1'b1;
                            w_tx       = REVERSE ? f_rev(w_sr_in) : w_sr_in;
                            w_state    = S_TX;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                S_TX: begin
                    if (w_shift) begin
                        w_miso = r_tx[DATA_W-1];
                        w_tx   = {r_tx[DATA_W-2:0], 1'b0};
                    end
                    if (w_sample) begin
                        if (r_cnt == LAST) begin
                            w_cnt   = '0;
                            w_state = S_RX;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_miso  = 1'b1;
                end
            endcase
        end
    end

    assign miso      = r_miso;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Directed bench: one SPI master drives six slave instances covering
// all modes, echo/reverse and a 16-bit word.
module tb_spi_bitrev_slave;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        mosi;
    logic [5:0]  ss;
    logic [5:0]  miso_v;
    logic [5:0]  rv;
    logic [5:0]  fe;
    logic [5:0]  bz;
    logic [31:0] rdat [6];

    int nv [6] = '{default: 0};
    int nf [6] = '{default: 0};

    int n_chk  = 0;
    int n_pass = 0;

    int cur_dev;
    bit cur_cpol;
    bit cur_cpha;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : gd
        localparam int W = (g == 5) ? 16 : 8;
        logic [W-1:0] rd;
        spi_bitrev_slave #(
            .DATA_W (W),
            .CPOL   (g == 3 || g == 4),
            .CPHA   (g == 2 || g == 4),
            .REVERSE(g == 0 || g == 5)
        ) u_dut (
            .clock    (clk),
            .resetn   (rst_n),
            .sck      (sck),
            .ss       (ss[g]),
            .mosi     (mosi),
            .miso     (miso_v[g]),
            .rx_data  (rd),
            .rx_valid (rv[g]),
            .frame_err(fe[g]),
            .busy     (bz[g])
        );
        assign rdat[g] = 32'(rd);
        always @(negedge clk) begin
            if (rv[g] === 1'b1) nv[g]++;
            if (fe[g] === 1'b1) nf[g]++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input bit b, output logic m);
        if (!cur_cpha) begin
            mosi = b;
            clks(H);
            sck = ~cur_cpol;
            m = miso_v[cur_dev];
            clks(H);
            sck = cur_cpol;
        end else begin
            sck = ~cur_cpol;
            mosi = b;
            clks(H);
            sck = cur_cpol;
            m = miso_v[cur_dev];
            clks(H);
        end
    endtask

    task automatic word(input logic [31:0] d, input int n,
                        output logic [31:0] r);
        logic m;
        r = '0;
        for (int i = n - 1; i >= 0; i--) slot(d[i], m);
        for (int i = 0; i < n; i++) begin
            slot(1'b0, m);
            r = {r[30:0], m};
        end
    endtask

    task automatic fbegin(input int dev, input bit cpol, input bit cpha);
        cur_dev  = dev;
        cur_cpol = cpol;
        cur_cpha = cpha;
        sck  = cpol;
        mosi = 1'b0;
        clks(6);
        ss[dev] = 1'b0;
        clks(H);
    endtask

    task automatic fend();
        clks(H);
        ss[cur_dev] = 1'b1;
        clks(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ss    = '1;
        sck   = 1'b0;
        mosi  = 1'b0;
        clks(3);
        for (int g = 0; g < 6; g++) begin
            n_chk++;
            if (miso_v[g] !== 1'b1 || bz[g] !== 1'b0)
                $display("FAIL reset_idle dev%0d miso=%b busy=%b want 1/0",
                         g, miso_v[g], bz[g]);
            else n_pass++;
        end
        n_chk++;
        if (rdat[0] !== 32'h0 || rv[0] !== 1'b0 || fe[0] !== 1'b0)
            $display("FAIL reset_outs rx=%h v=%b fe=%b want 0/0/0",
                     rdat[0], rv[0], fe[0]);
        else n_pass++;
        rst_n = 1'b1;
        clks(4);
    endtask

    task automatic test_mode0_rev();
        logic [31:0] r;
        int bv = nv[0];
        int bf = nf[0];
        fbegin(0, 1'b0, 1'b0);
        n_chk++;
        if (miso_v[0] !== 1'b1)
            $display("FAIL m0_miso_before got %b want 1", miso_v[0]);
        else n_pass++;
        word(32'h1E, 8, r);
        n_chk++;
        if (r !== 32'h78) $display("FAIL m0_read got %h want 78", r);
        else n_pass++;
        fend();
        n_chk++;
        if (nv[0] - bv !== 1 || rdat[0] !== 32'h1E)
            $display("FAIL m0_rx pulses=%0d rx=%h want 1/1e",
                     nv[0] - bv, rdat[0]);
        else n_pass++;
        n_chk++;
        if (miso_v[0] !== 1'b1 || bz[0] !== 1'b0 || nf[0] != bf)
            $display("FAIL m0_after miso=%b busy=%b ferr=%0d want 1/0/0",
                     miso_v[0], bz[0], nf[0] - bf);
        else n_pass++;
    endtask

    task automatic test_echo_modes();
        logic [31:0] r;
        int bv;
        for (int d = 1; d <= 4; d++) begin
            bv = nv[d];
            fbegin(d, (d == 3 || d == 4), (d == 2 || d == 4));
            word(32'h1E, 8, r);
            fend();
            n_chk++;
            if (r !== 32'h1E || rdat[d] !== 32'h1E || nv[d] - bv !== 1)
                $display("FAIL echo_dev%0d read=%h rx=%h pulses=%0d want 1e/1e/1",
                         d, r, rdat[d], nv[d] - bv);
            else n_pass++;
            n_chk++;
            if (miso_v[d] !== 1'b1)
                $display("FAIL echo_dev%0d_idle miso=%b want 1", d, miso_v[d]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  tx [3] = '{8'h01, 8'h80, 8'hFF};
        logic [7:0]  ex [3] = '{8'h80, 8'h01, 8'hFF};
        int bv = nv[0];
        fbegin(0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            word(32'(tx[k]), 8, r);
            n_chk++;
            if (r !== 32'(ex[k]) || rdat[0] !== 32'(tx[k]))
                $display("FAIL burst_w%0d read=%h rx=%h want %h/%h",
                         k, r, rdat[0], ex[k], tx[k]);
            else n_pass++;
        end
        fend();
        n_chk++;
        if (nv[0] - bv !== 3)
            $display("FAIL burst_pulses got %0d want 3", nv[0] - bv);
        else n_pass++;
    endtask

    task automatic test_wide();
        logic [31:0] r;
        fbegin(5, 1'b0, 1'b0);
        word(32'h1234, 16, r);
        fend();
        n_chk++;
        if (r !== 32'h2C48 || rdat[5] !== 32'h1234)
            $display("FAIL w16 read=%h rx=%h want 2c48/1234", r, rdat[5]);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic m;
        logic [31:0] r;
        int bv = nv[0];
        int bf = nf[0];
        fbegin(0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) slot(1'b1, m);
        fend();
        n_chk++;
        if (nf[0] - bf !== 1 || nv[0] != bv)
            $display("FAIL abort_pulses ferr=%0d valid=%0d want 1/0",
                     nf[0] - bf, nv[0] - bv);
        else n_pass++;
        n_chk++;
        if (miso_v[0] !== 1'b1 || bz[0] !== 1'b0 || rdat[0] !== 32'hFF)
            $display("FAIL abort_state miso=%b busy=%b rx=%h want 1/0/ff",
                     miso_v[0], bz[0], rdat[0]);
        else n_pass++;
        fbegin(0, 1'b0, 1'b0);
        word(32'h1E, 8, r);
        fend();
        n_chk++;
        if (r !== 32'h78) $display("FAIL abort_next got %h want 78", r);
        else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic m;
        logic [31:0] r;
        fbegin(0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) slot(1'(8'hA5 >> i), m);
        for (int i = 0; i < 3; i++) slot(1'b0, m);
        n_chk++;
        if (bz[0] !== 1'b1) $display("FAIL rst_pre busy=%b want 1", bz[0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (miso_v[0] !== 1'b1 || bz[0] !== 1'b0 || rdat[0] !== 32'h0)
            $display("FAIL rst_async miso=%b busy=%b rx=%h want 1/0/0",
                     miso_v[0], bz[0], rdat[0]);
        else n_pass++;
        ss[0] = 1'b1;
        sck   = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        fbegin(0, 1'b0, 1'b0);
        word(32'h1E, 8, r);
        fend();
        n_chk++;
        if (r !== 32'h78 || rdat[0] !== 32'h1E)
            $display("FAIL rst_fresh read=%h rx=%h want 78/1e", r, rdat[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mode0_rev();
        test_echo_modes();
        test_back_to_back();
        test_wide();
        test_abort();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
